// File: rtl/vga_timing_rx.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_rx
// Purpose  : Receives VGA-style sync/blanking signals and measures their
//            timing against the configured video mode. Once two consecutive
//            frames match, the block reports lock. It then emits per-pixel
//            column/row coordinates. Any timing deviation while locked drops
//            lock and raises a single-cycle error pulse.
// Ports    : clk          - pixel clock
//            reset        - asynchronous active-high reset
//            hsync/vsync  - active-low syncs, synchronous to clk
//            display_en   - high during active pixels
//            xcoord/ycoord- active pixel column / row (0 when not valid)
//            pixel_valid  - coordinates belong to the current pixel
//            frame_start  - one-cycle pulse per vsync falling edge
//            locked       - incoming timing matches the parameters
//            timing_err   - one-cycle pulse when lock is lost
//            line_len     - last measured clocks per line
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_rx #(
    parameter int H_SYNC_WAIT   = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int SCREEN_WIDTH  = 640,
    parameter int LINE_WAIT     = 800,
    parameter int V_SYNC_WAIT   = 2,
    parameter int V_BACK_PORCH  = 33,
    parameter int SCREEN_HEIGHT = 480,
    parameter int V_LINES_WAIT  = 525
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       display_en,
    output logic [9:0] xcoord,
    output logic [9:0] ycoord,
    output logic       pixel_valid,
    output logic       frame_start,
    output logic       locked,
    output logic       timing_err,
    output logic [9:0] line_len
);

    localparam logic [9:0]  c_CNT_MAX       = 10'd1023;
    localparam logic [9:0]  c_LINE_WAIT     = 10'(LINE_WAIT);
    localparam logic [9:0]  c_SCREEN_WIDTH  = 10'(SCREEN_WIDTH);
    localparam logic [10:0] c_V_LINES_WAIT  = 11'(V_LINES_WAIT);
    localparam logic [10:0] c_SCREEN_HEIGHT = 11'(SCREEN_HEIGHT);

    // A mode whose intervals do not fit in a line/frame, or whose totals do
    // not fit the 10-bit counters, can never be matched; such a
    // configuration reports a permanent mismatch instead of locking on a
    // truncated value.
    localparam bit c_H_FIT      = (H_SYNC_WAIT + H_BACK_PORCH + SCREEN_WIDTH) <= LINE_WAIT;
    localparam bit c_V_FIT      = (V_SYNC_WAIT + V_BACK_PORCH + SCREEN_HEIGHT) <= V_LINES_WAIT;
    localparam bit c_RANGE_OK   = (LINE_WAIT < 1023) && (V_LINES_WAIT < 1023);
    localparam bit c_PARAMS_OK  = c_H_FIT && c_V_FIT && c_RANGE_OK;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input staging and edge detection
    // ------------------------------------------------------------------
    logic r_hs_s1, r_hs_s2, r_vs_s1, r_vs_s2, r_de_s1;
    logic w_hs_fall, w_vs_fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hs_s1 <= 1'b1;
            r_hs_s2 <= 1'b1;
            r_vs_s1 <= 1'b1;
            r_vs_s2 <= 1'b1;
            r_de_s1 <= 1'b0;
        end else begin
            r_hs_s1 <= hsync;
            r_hs_s2 <= r_hs_s1;
            r_vs_s1 <= vsync;
            r_vs_s2 <= r_vs_s1;
            r_de_s1 <= display_en;
        end
    end

    assign w_hs_fall = r_hs_s2 & ~r_hs_s1;
    assign w_vs_fall = r_vs_s2 & ~r_vs_s1;

    // ------------------------------------------------------------------
    // Measurement counters
    // ------------------------------------------------------------------
    logic [9:0] r_hcnt, r_vcnt, r_acnt, r_lcnt, r_line_len;
    logic       r_frame_start;
    logic       w_line_active;

    // The line that just ended carried active pixels.
    assign w_line_active = w_hs_fall && (r_acnt != 10'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hcnt        <= 10'd0;
            r_vcnt        <= 10'd0;
            r_acnt        <= 10'd0;
            r_lcnt        <= 10'd0;
            r_line_len    <= 10'd0;
            r_frame_start <= 1'b0;
        end else begin
            if (w_hs_fall) begin
                r_hcnt     <= 10'd1;
                r_line_len <= r_hcnt;
            end else if (r_hcnt != c_CNT_MAX) begin
                r_hcnt <= r_hcnt + 10'd1;
            end

            // vsync clear wins over a coincident hsync edge.
            if (w_vs_fall) begin
                r_vcnt <= 10'd0;
            end else if (w_hs_fall && (r_vcnt != c_CNT_MAX)) begin
                r_vcnt <= r_vcnt + 10'd1;
            end

            if (w_hs_fall) begin
                r_acnt <= 10'd0;
            end else if (r_de_s1 && (r_acnt != c_CNT_MAX)) begin
                r_acnt <= r_acnt + 10'd1;
            end

            if (w_vs_fall) begin
                r_lcnt <= 10'd0;
            end else if (w_line_active && (r_lcnt != c_CNT_MAX)) begin
                r_lcnt <= r_lcnt + 10'd1;
            end

            r_frame_start <= w_vs_fall;
        end
    end

    // ------------------------------------------------------------------
    // Mismatch detection
    // ------------------------------------------------------------------
    // A hsync edge that coincides with the vsync edge is swallowed by the
    // vcnt/lcnt clear, yet it still closes a line of the finishing frame;
    // it is added back before the frame totals are compared.
    logic [10:0] w_vcnt_eff, w_lcnt_eff;
    logic        w_line_mm, w_frame_mm, w_lost_hs, w_mismatch;

    assign w_vcnt_eff = {1'b0, r_vcnt} + {10'd0, w_hs_fall};
    assign w_lcnt_eff = {1'b0, r_lcnt} + {10'd0, w_line_active};

    assign w_line_mm  = w_hs_fall &&
                        ((r_hcnt != c_LINE_WAIT) ||
                         ((r_acnt != 10'd0) && (r_acnt != c_SCREEN_WIDTH)));
    assign w_frame_mm = w_vs_fall &&
                        ((w_vcnt_eff != c_V_LINES_WAIT) ||
                         (w_lcnt_eff != c_SCREEN_HEIGHT));
    assign w_lost_hs  = (r_hcnt == c_CNT_MAX) && !w_hs_fall;
    assign w_mismatch = w_line_mm || w_frame_mm || w_lost_hs || !c_PARAMS_OK;

    // ------------------------------------------------------------------
    // Lock state machine
    // ------------------------------------------------------------------
    state_t r_state, w_state_next;
    logic   r_dirty, w_dirty_next;   // mismatch seen in current CHECK window
    logic   r_timing_err, w_err_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= SEARCH;
            r_dirty      <= 1'b0;
            r_timing_err <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_dirty      <= w_dirty_next;
            r_timing_err <= w_err_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_dirty_next = r_dirty;
        w_err_next   = 1'b0;
        case (r_state)
            SEARCH: begin
                // Whatever was measured before this edge is stale.
                if (w_vs_fall) begin
                    w_state_next = CHECK;
                    w_dirty_next = 1'b0;
                end
            end
            CHECK: begin
                if (w_vs_fall) begin
                    if (!r_dirty && !w_mismatch) begin
                        w_state_next = LOCKED;
                    end
                    w_dirty_next = 1'b0;
                end else if (w_mismatch) begin
                    w_dirty_next = 1'b1;
                end
            end
            LOCKED: begin
                if (w_mismatch) begin
                    w_state_next = SEARCH;
                    w_err_next   = 1'b1;
                end
            end
            default: begin
                w_state_next = SEARCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pixel coordinate outputs
    // ------------------------------------------------------------------
    logic       r_pixel_valid;
    logic [9:0] r_xcoord, r_ycoord;
    logic       w_pix;

    assign w_pix = r_de_s1 && (r_state == LOCKED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pixel_valid <= 1'b0;
            r_xcoord      <= 10'd0;
            r_ycoord      <= 10'd0;
        end else begin
            r_pixel_valid <= w_pix;
            r_xcoord      <= w_pix ? r_acnt : 10'd0;
            r_ycoord      <= w_pix ? r_lcnt : 10'd0;
        end
    end

    assign xcoord      = r_xcoord;
    assign ycoord      = r_ycoord;
    assign pixel_valid = r_pixel_valid;
    assign frame_start = r_frame_start;
    assign locked      = (r_state == LOCKED);
    assign timing_err  = r_timing_err;
    assign line_len    = r_line_len;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_rx
// Purpose  : Self-checking bench for vga_timing_rx using a reduced video
//            mode (20 clocks x 12 lines, 8 x 5 active) driven by a local
//            sync generator, with a table of single-line disturbances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_rx;

    localparam int HSW = 4;
    localparam int HBP = 3;
    localparam int SW  = 8;
    localparam int LW  = 20;
    localparam int VSW = 2;
    localparam int VBP = 2;
    localparam int SH  = 5;
    localparam int VL  = 12;
    localparam int HS_START = LW - HBP - HSW;   // 13
    localparam int VS_START = VL - VBP - VSW;   // 8

    logic       clk = 1'b0;
    logic       reset;
    logic       hsync, vsync, display_en;
    logic [9:0] xcoord, ycoord, line_len;
    logic       pixel_valid, frame_start, locked, timing_err;

    vga_timing_rx #(
        .H_SYNC_WAIT  (HSW),
        .H_BACK_PORCH (HBP),
        .SCREEN_WIDTH (SW),
        .LINE_WAIT    (LW),
        .V_SYNC_WAIT  (VSW),
        .V_BACK_PORCH (VBP),
        .SCREEN_HEIGHT(SH),
        .V_LINES_WAIT (VL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hsync      (hsync),
        .vsync      (vsync),
        .display_en (display_en),
        .xcoord     (xcoord),
        .ycoord     (ycoord),
        .pixel_valid(pixel_valid),
        .frame_start(frame_start),
        .locked     (locked),
        .timing_err (timing_err),
        .line_len   (line_len)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int err_cnt, fs_cnt, pv_cnt;
    int first_x, first_y, last_x, last_y;
    int err_gap, err_len, err_pv, err_locked_prev, err_locked_now;
    int lock_rise_gap;
    int last_hs_cyc = 0;
    int last_vs_cyc = 0;
    int zero_bad = 0;
    bit got_first, prev_locked = 1'b0, prev_hs = 1'b1, prev_vs = 1'b1;

    typedef struct {
        int flen;       // clocks in the disturbed line
        int fde;        // display_en clocks in the disturbed line
        bit fhs;        // hsync pulse present in the disturbed line
        int exp_err;    // expected timing_err pulses
        int exp_gap;    // clocks from hsync-low drive to timing_err sample
        int exp_len;    // line_len when timing_err is seen
        int exp_lock;   // locked at end of the disturbed frame
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        err_cnt = 0; fs_cnt = 0; pv_cnt = 0; got_first = 1'b0;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1;
        err_gap = -1; err_len = -1; err_pv = -1;
        err_locked_prev = -1; err_locked_now = -1; lock_rise_gap = -1;
    endtask

    // One pixel clock: drive at the falling edge, observe 1 ns after the
    // following rising edge.
    task automatic step(input logic hs, input logic vs, input logic de);
        @(negedge clk);
        if (prev_hs && !hs) last_hs_cyc = cyc;
        if (prev_vs && !vs) last_vs_cyc = cyc;
        prev_hs = hs;
        prev_vs = vs;
        hsync = hs;
        vsync = vs;
        display_en = de;
        @(posedge clk);
        #1;
        if (timing_err) begin
            err_cnt++;
            err_gap         = cyc - last_hs_cyc;
            err_len         = int'(line_len);
            err_pv          = int'(pixel_valid);
            err_locked_prev = int'(prev_locked);
            err_locked_now  = int'(locked);
        end
        if (frame_start) fs_cnt++;
        if (locked && !prev_locked) lock_rise_gap = cyc - last_vs_cyc;
        if (pixel_valid) begin
            if (!got_first) begin
                first_x = int'(xcoord);
                first_y = int'(ycoord);
                got_first = 1'b1;
            end
            last_x = int'(xcoord);
            last_y = int'(ycoord);
            pv_cnt++;
        end else if (xcoord != 10'd0 || ycoord != 10'd0) begin
            zero_bad++;
        end
        prev_locked = locked;
        cyc++;
    endtask

    task automatic run_line(input int v, input int len, input int de_len,
                            input bit hs_on, input bit coinc);
        int  tv;
        logic hs, vs, de;
        tv = coinc ? HS_START : 0;
        for (int h = 0; h < len; h++) begin
            hs = !(hs_on && h >= HS_START && h < HS_START + HSW);
            vs = !(((v > VS_START) || (v == VS_START && h >= tv)) &&
                   ((v < VS_START + VSW) || (v == VS_START + VSW && h < tv)));
            de = (v < SH) && (h < de_len);
            step(hs, vs, de);
        end
    endtask

    task automatic run_frame(input bit coinc, input int fv, input int flen,
                             input int fde, input bit fhs);
        for (int v = 0; v < VL; v++) begin
            if (v == fv) run_line(v, flen, fde, fhs, coinc);
            else         run_line(v, LW, SW, 1'b1, coinc);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0);
    endtask

    function automatic int outs_nonzero();
        return int'(|{xcoord, ycoord, line_len, pixel_valid,
                      frame_start, locked, timing_err});
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // disturbed line is line 2 (active) of an otherwise nominal frame
        vecs[0] = '{flen: LW,   fde: SW,     fhs: 1'b1, exp_err: 0, exp_gap: -1,   exp_len: -1, exp_lock: 1};
        vecs[1] = '{flen: LW+1, fde: SW,     fhs: 1'b1, exp_err: 1, exp_gap: 1,    exp_len: 21, exp_lock: 0};
        vecs[2] = '{flen: LW,   fde: SW+1,   fhs: 1'b1, exp_err: 1, exp_gap: 1,    exp_len: 20, exp_lock: 0};
        vecs[3] = '{flen: 1100, fde: SW,     fhs: 1'b0, exp_err: 1, exp_gap: 1024, exp_len: 20, exp_lock: 0};

        hsync = 1'b1; vsync = 1'b1; display_en = 1'b0;
        reset = 1'b1;
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs_nonzero(), 0);
        @(negedge clk);
        reset = 1'b0;

        // First frame: one vsync edge only, no lock yet.
        clear_stats();
        run_frame(1'b0, -1, LW, SW, 1'b1);
        check("lock_after_one_frame", int'(locked), 0);
        run_frame(1'b0, -1, LW, SW, 1'b1);
        check("lock_rise_latency", lock_rise_gap, 1);
        check("locked_after_two", int'(locked), 1);
        check("frame_start_count", fs_cnt, 2);

        // Locked frame: full coordinate sweep.
        clear_stats();
        run_frame(1'b0, -1, LW, SW, 1'b1);
        check("first_x", first_x, 0);
        check("first_y", first_y, 0);
        check("last_x", last_x, SW - 1);
        check("last_y", last_y, SH - 1);
        check("pixel_count", pv_cnt, SW * SH);
        check("line_len_nominal", int'(line_len), LW);
        check("no_err_nominal", err_cnt, 0);

        // Disturbance table.
        for (int i = 0; i < 4; i++) begin
            int n;
            n = 0;
            while (!locked && n < 4) begin
                run_frame(1'b0, -1, LW, SW, 1'b1);
                n++;
            end
            check($sformatf("v%0d_relock", i), int'(locked), 1);
            clear_stats();
            run_frame(1'b0, 2, vecs[i].flen, vecs[i].fde, vecs[i].fhs);
            check($sformatf("v%0d_err_pulses", i), err_cnt, vecs[i].exp_err);
            check($sformatf("v%0d_locked_end", i), int'(locked), vecs[i].exp_lock);
            if (vecs[i].exp_err > 0) begin
                check($sformatf("v%0d_err_gap", i), err_gap, vecs[i].exp_gap);
                check($sformatf("v%0d_line_len", i), err_len, vecs[i].exp_len);
                check($sformatf("v%0d_pv_at_err", i), err_pv, 0);
                check($sformatf("v%0d_locked_before", i), err_locked_prev, 1);
                check($sformatf("v%0d_locked_at_err", i), err_locked_now, 0);
            end
        end

        // Asynchronous reset in the middle of a locked frame.
        begin
            int n;
            n = 0;
            while (!locked && n < 4) begin
                run_frame(1'b0, -1, LW, SW, 1'b1);
                n++;
            end
        end
        for (int v = 0; v < 3; v++) run_line(v, LW, SW, 1'b1, 1'b0);
        check("pre_reset_locked", int'(locked), 1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs", outs_nonzero(), 0);
        idle(3);
        @(negedge clk);
        reset = 1'b0;
        clear_stats();
        idle(10);
        check("no_frame_start_on_release", fs_cnt, 0);
        check("unlocked_after_reset", int'(locked), 0);
        run_frame(1'b0, -1, LW, SW, 1'b1);
        check("reset_relock_first", int'(locked), 0);
        run_frame(1'b0, -1, LW, SW, 1'b1);
        check("reset_relock_second", int'(locked), 1);

        // hsync and vsync falling together.
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        @(negedge clk);
        reset = 1'b0;
        clear_stats();
        run_frame(1'b1, -1, LW, SW, 1'b1);
        check("coinc_fs_one", fs_cnt, 1);
        run_frame(1'b1, -1, LW, SW, 1'b1);
        check("coinc_fs_two", fs_cnt, 2);
        check("coinc_locked", int'(locked), 1);
        run_frame(1'b1, -1, LW, SW, 1'b1);
        check("coinc_stays_locked", int'(locked), 1);
        check("coinc_no_err", err_cnt, 0);

        check("coords_zero_when_invalid", zero_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_rx.md
VGA_TIMING_RX -- requirements
Module: vga_timing_rx

Interface
REQ-001 SHALL have parameter H_SYNC_WAIT, default 96, hsync low width in clocks.
REQ-002 SHALL have parameter H_BACK_PORCH, default 48, clocks from hsync rise to first active pixel.
REQ-003 SHALL have parameter SCREEN_WIDTH, default 640, active pixels per line.
REQ-004 SHALL have parameter LINE_WAIT, default 800, clocks per line.
REQ-005 SHALL have parameter V_SYNC_WAIT, default 2, vsync low width in lines.
REQ-006 SHALL have parameter V_BACK_PORCH, default 33, lines from vsync rise to first active line.
REQ-007 SHALL have parameter SCREEN_HEIGHT, default 480, active lines per frame.
REQ-008 SHALL have parameter V_LINES_WAIT, default 525, lines per frame.
REQ-009 SHALL have port clk, input, 1, pixel clock; the block's only clock.
REQ-010 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-011 SHALL have port hsync, input, 1, active-low horizontal sync, synchronous to clk.
REQ-012 SHALL have port vsync, input, 1, active-low vertical sync, synchronous to clk.
REQ-013 SHALL have port display_en, input, 1, high during active pixels.
REQ-014 SHALL have port xcoord, output, 10, active pixel column.
REQ-015 SHALL have port ycoord, output, 10, active line row.
REQ-016 SHALL have port pixel_valid, output, 1, xcoord/ycoord valid for current pixel.
REQ-017 SHALL have port frame_start, output, 1, one-cycle pulse on vsync falling edge.
REQ-018 SHALL have port locked, output, 1, timing matches parameters.
REQ-019 SHALL have port timing_err, output, 1, one-cycle pulse on mismatch detected.
REQ-020 SHALL have port line_len, output, 10, last measured clocks per line.

Function
REQ-021 SHALL register hsync, vsync, display_en into stage s1, then s1 into s2; falling edge = s2 high and s1 low.
REQ-022 SHALL run 10-bit hcnt: cleared to 1 on hsync falling edge, else incremented, saturating at 1023.
REQ-023 SHALL, on hsync falling edge, load line_len with hcnt and increment 10-bit line counter vcnt (saturating at 1023).
REQ-024 SHALL, on vsync falling edge, clear vcnt to 0 and pulse frame_start for one cycle; a same-cycle hsync falling edge SHALL leave vcnt at 0.
REQ-025 SHALL count s1 display_en cycles per line in acnt (cleared on hsync falling edge) and active lines per frame in lcnt (cleared on vsync falling edge).
REQ-026 SHALL flag line mismatch at hsync falling edge when hcnt != LINE_WAIT, or acnt nonzero and != SCREEN_WIDTH.
REQ-027 SHALL flag frame mismatch at vsync falling edge when vcnt != V_LINES_WAIT or lcnt != SCREEN_HEIGHT.
REQ-028 SHALL flag mismatch when hcnt reaches 1023 (lost hsync).
REQ-029 SHALL implement FSM SEARCH, CHECK, LOCKED; locked = (state == LOCKED).
REQ-030 SEARCH -> CHECK on vsync falling edge.
REQ-031 CHECK -> LOCKED on next vsync falling edge if no mismatch flagged since entering CHECK; else stay CHECK and restart the check window.
REQ-032 LOCKED -> SEARCH on any mismatch, with timing_err high for exactly that cycle; mismatches outside LOCKED SHALL NOT pulse timing_err.
REQ-033 SHALL drive xcoord = acnt before increment and ycoord = lcnt for each s1 display_en cycle, registered; pixel_valid = registered (s1 display_en and locked); latency 2 clocks from display_en input.
REQ-034 SHALL hold xcoord and ycoord at 0 while pixel_valid is low.

Reset
REQ-035 SHALL, while reset high, force state SEARCH; xcoord, ycoord, line_len, hcnt, vcnt, acnt, lcnt = 0; pixel_valid, frame_start, locked, timing_err = 0; s1/s2 hsync and vsync = 1, display_en = 0.
REQ-036 SHALL treat reset asserted mid-frame identically; relock requires two fresh vsync falling edges.

Verification
REQ-037 Assert reset mid-operation -> all outputs 0 within same cycle, no frame_start on release with syncs high.
REQ-038 Drive two nominal 800x525 frames from the generator with default parameters -> locked rises 1 cycle after second vsync falling edge is registered; next frame first pixel_valid shows 0,0, last shows 639,479; line_len = 800.
REQ-039 While locked, stretch one line to 801 clocks -> timing_err single pulse at that hsync falling edge, locked drops same cycle, line_len = 801.
REQ-040 While locked, hold hsync high 1100 clocks -> timing_err pulse when hcnt hits 1023, locked = 0, pixel_valid = 0.
REQ-041 While locked, drive display_en for 641 clocks in one line -> timing_err at following hsync falling edge, FSM to SEARCH.
REQ-042 Hsync and vsync falling on same cycle -> vcnt = 0, frame_start pulses once, lock still achieved on nominal frames.
